sram_port_arbiter: RTL and testbench

- Shares one synchronous single-port SRAM between two requesters: the fetch stage (instruction reads) and the execute stage (data loads and stores).
- Sits between the pipeline stages and the unified SRAM.
- Grants at most one access per cycle, using fixed priority (data over instruction) plus a starvation guard.
- Tracks which requester owns the outstanding read, and routes the SRAM read data back to that requester one cycle later.

---
 rtl/sram_arb_pkg.sv | 16 +
 rtl/sram_arb_starve_cnt.sv | 43 ++++
 rtl/sram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the fetch/execute SRAM port arbiter.
//   OWN_*               : encoding of which requester owns the read in flight
//   STARVE_MAX_DEFAULT  : default number of consecutive losses an instruction
//                         fetch may suffer before it is forced to win
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_INST = 2'd1;
    localparam logic [1:0] OWN_DATA = 2'd2;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/sram_arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// sram_arb_starve_cnt
// Saturating count of consecutive cycles in which a pending instruction fetch
// lost arbitration to a data access. Raises force_inst once the count reaches
// STARVE_MAX so the fetch wins the next arbitration.
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   inst_req     : fetch request pending this cycle
//   grant_inst   : fetch granted this cycle (clears the count)
//   grant_data   : data access granted this cycle
//   force_inst   : fetch must win this cycle
// ---------------------------------------------------------------------------
module sram_arb_starve_cnt
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic grant_inst,
    input  logic grant_data,
    output logic force_inst
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    assign force_inst = inst_req & (starve_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (grant_inst || !inst_req) begin
            starve_cnt <= '0;
        end else if (grant_data && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
// Shares one synchronous single-port SRAM between the fetch stage (reads) and
// the execute stage (loads/stores). Data wins by fixed priority unless the
// fetch has been starved for STARVE_MAX cycles. Read data returns one cycle
// after the grant and is flagged valid only for the requester that owns it.
// Ports:
//   clk, resetn                    : clock, synchronous active-low reset
//   inst_req/addr, inst_addr_ok    : fetch request and same-cycle accept
//   inst_rdata_valid, inst_rdata   : fetch response (latency 1)
//   data_req/we/addr/wdata         : execute request (we == 0 means load)
//   data_addr_ok                   : execute same-cycle accept
//   data_rdata_valid, data_rdata   : load response (latency 1, loads only)
//   sram_en/we/addr/wdata/rdata    : SRAM port
// Optional: define SRAM_ARB_PERF_CNT_EN to add perf_conflict_cnt (cycles with
// both requests) and perf_force_cnt (cycles with a forced fetch grant).
// ---------------------------------------------------------------------------
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_rdata_valid,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_rdata_valid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
`ifdef SRAM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_conflict_cnt,
    output logic [31:0]         perf_force_cnt
`endif
);

    logic       force_inst;
    logic       grant_inst;
    logic       grant_data;
    logic [1:0] owner_p1;

    // Stage p0: arbitration and SRAM drive
    always_comb begin
        grant_data = resetn & data_req & ~force_inst;
        grant_inst = resetn & inst_req & ~grant_data;
    end

    sram_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .inst_req   (inst_req),
        .grant_inst (grant_inst),
        .grant_data (grant_data),
        .force_inst (force_inst)
    );

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    // The enable and write strobes are built only from grants so an idle
    // port never drives X onto them; address/wdata may follow either side.
    always_comb begin
        sram_en    = grant_inst | grant_data;
        sram_we    = grant_data ? data_we    : '0;
        sram_addr  = grant_data ? data_addr  : inst_addr;
        sram_wdata = grant_data ? data_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_p1 <= OWN_NONE;
        end else if (grant_inst) begin
            owner_p1 <= OWN_INST;
        end else if (grant_data && (data_we == '0)) begin
            owner_p1 <= OWN_DATA;
        end else begin
            owner_p1 <= OWN_NONE;
        end
    end

    // Stage p1: response routing
    // Gating with resetn drops a read that was in flight when reset arrived.
    assign inst_rdata_valid = resetn & (owner_p1 == OWN_INST);
    assign data_rdata_valid = resetn & (owner_p1 == OWN_DATA);
    assign inst_rdata       = sram_rdata;
    assign data_rdata       = sram_rdata;

`ifdef SRAM_ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_conflict_cnt <= '0;
            perf_force_cnt    <= '0;
        end else begin
            if (inst_req && data_req) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (force_inst) begin
                perf_force_cnt <= perf_force_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter with a behavioural single-port SRAM.
// Inputs change on the falling edge; outputs are sampled 2 ns later.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              resetn;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_rdata_valid;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic [3:0]        data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_rdata_valid;
    logic [DATA_W-1:0] data_rdata;
    logic              sram_en;
    logic [3:0]        sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
`ifdef SRAM_ARB_PERF_CNT_EN
    logic [31:0]       perf_conflict_cnt;
    logic [31:0]       perf_force_cnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .STARVE_MAX (4),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .inst_req         (inst_req),
        .inst_addr        (inst_addr),
        .inst_addr_ok     (inst_addr_ok),
        .inst_rdata_valid (inst_rdata_valid),
        .inst_rdata       (inst_rdata),
        .data_req         (data_req),
        .data_we          (data_we),
        .data_addr        (data_addr),
        .data_wdata       (data_wdata),
        .data_addr_ok     (data_addr_ok),
        .data_rdata_valid (data_rdata_valid),
        .data_rdata       (data_rdata),
        .sram_en          (sram_en),
        .sram_we          (sram_we),
        .sram_addr        (sram_addr),
        .sram_wdata       (sram_wdata),
        .sram_rdata       (sram_rdata)
`ifdef SRAM_ARB_PERF_CNT_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_force_cnt    (perf_force_cnt)
`endif
    );

    // Behavioural SRAM: 256 words indexed by addr[9:2], one-cycle read.
    logic [31:0] mem [256];

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'h0) begin
                sram_rdata <= mem[sram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and apply a new input set.
    task automatic drive(input logic rn, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [3:0] dw,
                         input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        resetn     = rn;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_we    = dw;
        data_addr  = da;
        data_wdata = dd;
        #2;
    endtask

    localparam logic [31:0] IA = 32'h1C00_0000;
    localparam logic [31:0] DA = 32'h0000_0100;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]     = 32'hDEAD_BEEF;
        sram_rdata = 32'h0;
        resetn = 1'b0; inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_we = '0; data_addr = '0; data_wdata = '0;

        // Reset with both requests asserted: nothing may be granted.
        drive(1'b0, 1'b1, IA, 1'b1, 4'h0, DA, 32'h0);
        drive(1'b0, 1'b1, IA, 1'b1, 4'hF, DA, 32'h0);
        chk("rst_inst_ok",  {31'd0, inst_addr_ok}, 32'd0);
        chk("rst_data_ok",  {31'd0, data_addr_ok}, 32'd0);
        chk("rst_sram_en",  {31'd0, sram_en}, 32'd0);
        chk("rst_sram_we",  {28'd0, sram_we}, 32'd0);
        chk("rst_inst_vld", {31'd0, inst_rdata_valid}, 32'd0);
        chk("rst_data_vld", {31'd0, data_rdata_valid}, 32'd0);

        // Lone fetch.
        drive(1'b1, 1'b1, IA, 1'b0, 4'h0, DA, 32'h0);
        chk("fetch_ok",      {31'd0, inst_addr_ok}, 32'd1);
        chk("fetch_data_ok", {31'd0, data_addr_ok}, 32'd0);
        chk("fetch_en",      {31'd0, sram_en}, 32'd1);
        chk("fetch_addr",    sram_addr, IA);
        chk("fetch_we",      {28'd0, sram_we}, 32'd0);
        drive(1'b1, 1'b0, IA, 1'b0, 4'h0, DA, 32'h0);
        chk("fetch_vld",     {31'd0, inst_rdata_valid}, 32'd1);
        chk("fetch_rdata",   inst_rdata, 32'hDEAD_BEEF);
        chk("fetch_dvld",    {31'd0, data_rdata_valid}, 32'd0);
        chk("idle_en",       {31'd0, sram_en}, 32'd0);

        // Store, then load, then fetch back-to-back.
        drive(1'b1, 1'b0, IA, 1'b1, 4'hF, DA, 32'h1234_5678);
        chk("st_ok",    {31'd0, data_addr_ok}, 32'd1);
        chk("st_we",    {28'd0, sram_we}, 32'hF);
        chk("st_addr",  sram_addr, DA);
        chk("st_wdata", sram_wdata, 32'h1234_5678);
        chk("st_iok",   {31'd0, inst_addr_ok}, 32'd0);
        drive(1'b1, 1'b0, IA, 1'b1, 4'h0, DA, 32'h0);
        chk("st_no_vld", {31'd0, data_rdata_valid}, 32'd0);
        chk("ld_ok",     {31'd0, data_addr_ok}, 32'd1);
        chk("ld_we",     {28'd0, sram_we}, 32'd0);
        drive(1'b1, 1'b1, IA, 1'b0, 4'h0, DA, 32'h0);
        chk("ld_vld",    {31'd0, data_rdata_valid}, 32'd1);
        chk("ld_rdata",  data_rdata, 32'h1234_5678);
        chk("b2b_ivld0", {31'd0, inst_rdata_valid}, 32'd0);
        chk("b2b_iok",   {31'd0, inst_addr_ok}, 32'd1);
        drive(1'b1, 1'b0, IA, 1'b0, 4'h0, DA, 32'h0);
        chk("b2b_ivld",  {31'd0, inst_rdata_valid}, 32'd1);
        chk("b2b_irdat", inst_rdata, 32'hDEAD_BEEF);
        chk("b2b_dvld",  {31'd0, data_rdata_valid}, 32'd0);

        // Contention, STARVE_MAX=4: D D D D I D D D D I.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, IA, 1'b1, 4'h0, DA, 32'h0);
            chk($sformatf("cont_iok_%0d", i), {31'd0, inst_addr_ok}, (i % 5 == 4) ? 32'd1 : 32'd0);
            chk($sformatf("cont_dok_%0d", i), {31'd0, data_addr_ok}, (i % 5 == 4) ? 32'd0 : 32'd1);
            chk($sformatf("cont_addr_%0d", i), sram_addr, (i % 5 == 4) ? IA : DA);
        end
        drive(1'b1, 1'b0, IA, 1'b0, 4'h0, DA, 32'h0);
        chk("cont_last_ivld", {31'd0, inst_rdata_valid}, 32'd1);
`ifdef SRAM_ARB_PERF_CNT_EN
        chk("perf_conflict", perf_conflict_cnt, 32'd10);
        chk("perf_force",    perf_force_cnt, 32'd2);
`endif

        // Dropping inst_req clears the starvation count.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, IA, 1'b1, 4'h0, DA, 32'h0);
        drive(1'b1, 1'b0, IA, 1'b1, 4'h0, DA, 32'h0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, IA, 1'b1, 4'h0, DA, 32'h0);
            chk($sformatf("clr_iok_%0d", i), {31'd0, inst_addr_ok}, (i == 4) ? 32'd1 : 32'd0);
        end

        // Reset in the cycle after a fetch grant drops the response.
        drive(1'b1, 1'b0, IA, 1'b0, 4'h0, DA, 32'h0);
        drive(1'b1, 1'b1, IA, 1'b0, 4'h0, DA, 32'h0);
        chk("mid_iok", {31'd0, inst_addr_ok}, 32'd1);
        drive(1'b0, 1'b1, IA, 1'b1, 4'h0, DA, 32'h0);
        chk("mid_rst_ivld", {31'd0, inst_rdata_valid}, 32'd0);
        chk("mid_rst_iok",  {31'd0, inst_addr_ok}, 32'd0);
        chk("mid_rst_dok",  {31'd0, data_addr_ok}, 32'd0);
        chk("mid_rst_en",   {31'd0, sram_en}, 32'd0);
        drive(1'b1, 1'b0, IA, 1'b0, 4'h0, DA, 32'h0);
        chk("post_rst_ivld", {31'd0, inst_rdata_valid}, 32'd0);
        chk("post_rst_dvld", {31'd0, data_rdata_valid}, 32'd0);
`ifdef SRAM_ARB_PERF_CNT_EN
        chk("post_rst_perf", perf_conflict_cnt, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
